// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM encoding and instruction-memory constants for the boot controller
package mips_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
    localparam int MEM_DEPTH = 1024;
    localparam logic [5:0] HALT_OPCODE = 6'b111111;
endpackage

// File: rtl/imem_run_counter.sv
// imem_run_counter: saturating 32-bit cycle counter with synchronous clear and enable
module imem_run_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) count <= '0;
        else if (en && count != '1) count <= count + 32'd1;
    end
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a host program into instruction memory, then runs the CPU until a halt opcode
module imem_boot_ctrl
    import mips_pkg::*;
#(
    parameter int         MEM_DEPTH   = mips_pkg::MEM_DEPTH,
    parameter int         ADDR_W      = 10,
    parameter logic [5:0] HALT_OPCODE = mips_pkg::HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    input  logic [31:0]       cpu_pc,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [31:0]       mem_dpo,
    output logic [31:0]       cpu_instr,
    output logic              cpu_run,
    output logic              halted,
    output logic              err,
    output logic [31:0]       cycle_count
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    state_t state, state_n;
    logic [ADDR_W:0] cnt, len;
    logic len_ok, start, accept, last, pc_bad, op_halt;
    assign len_ok  = load_len != '0 && load_len <= DEPTH;
    assign start   = load_start && (state == IDLE || state == HALT);
    assign accept  = in_valid && in_ready;
    assign last    = accept && cnt == len - 1'b1;
    assign pc_bad  = |cpu_pc[31:ADDR_W];
    assign op_halt = mem_dpo[31:26] == HALT_OPCODE;
    assign mem_dpra  = cpu_pc[ADDR_W-1:0];
    assign cpu_instr = mem_dpo;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = start ? (len_ok ? LOAD : HALT) :
                  (state == LOAD && last) ? RUN :
                  (state == RUN && (pc_bad || op_halt)) ? HALT : state;
    end
    always_comb begin
        in_ready = state == LOAD;
        mem_we   = accept;
        mem_a    = cnt[ADDR_W-1:0];
        mem_d    = in_data;
        cpu_run  = state == RUN;
        halted   = state == HALT;
    end
    // A rejected length still lands in HALT with err set and nothing written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
            err <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            len <= load_len;
            err <= !len_ok;
        end else begin
            if (accept) cnt <= cnt + 1'b1;
            if (state == RUN && pc_bad) err <= 1'b1;
        end
    end
    imem_run_counter u_run_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start && len_ok),
        .en    (state == RUN),
        .count (cycle_count)
    );
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed vectors for load, run, halt, error and reset behaviour
module tb_imem_boot_ctrl;
    logic        clk = 0;
    logic        rst_n, load_start, in_valid, in_ready, mem_we, cpu_run, halted, err;
    logic [10:0] load_len;
    logic [31:0] in_data, mem_d, cpu_pc, mem_dpo, cpu_instr, cycle_count;
    logic [9:0]  mem_a, mem_dpra;
    int checks = 0, errors = 0;

    imem_boot_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .cpu_pc(cpu_pc),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo), .cpu_instr(cpu_instr),
        .cpu_run(cpu_run), .halted(halted), .err(err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load(input logic [10:0] n);
        load_start = 1; load_len = n;
        tick;
        load_start = 0;
    endtask

    initial begin
        rst_n = 0; load_start = 0; load_len = 0; in_valid = 0; in_data = 0;
        cpu_pc = 0; mem_dpo = 0;
        tick; tick;
        rst_n = 1;
        settle;
        chk("rst_ready", in_ready, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_cc", cycle_count, 0);
        chk("rst_we", mem_we, 0);
        // Illegal lengths: zero and one past the depth
        load(11'd0);
        chk("len0_err", err, 1);
        chk("len0_halt", halted, 1);
        chk("len0_we", mem_we, 0);
        chk("len0_ready", in_ready, 0);
        load(11'd1025);
        chk("len1025_err", err, 1);
        chk("len1025_halt", halted, 1);
        chk("len1025_we", mem_we, 0);
        // Back-to-back load of five words
        load(11'd5);
        chk("load_err_clr", err, 0);
        chk("load_halt_clr", halted, 0);
        chk("load_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 32'hA000_0000 + i;
            settle;
            chk($sformatf("b2b_we%0d", i), mem_we, 1);
            chk($sformatf("b2b_a%0d", i), mem_a, i);
            chk($sformatf("b2b_d%0d", i), mem_d, 32'hA000_0000 + i);
            tick;
        end
        in_valid = 0;
        settle;
        chk("b2b_run", cpu_run, 1);
        chk("b2b_ready_off", in_ready, 0);
        chk("b2b_we_off", mem_we, 0);
        chk("run_cc0", cycle_count, 0);
        // Three ordinary instructions, halt word on the fourth RUN cycle
        for (int i = 0; i < 3; i++) begin
            cpu_pc = i; mem_dpo = 32'h2000_0000 + i;
            settle;
            chk($sformatf("run_instr%0d", i), cpu_instr, 32'h2000_0000 + i);
            chk($sformatf("run_dpra%0d", i), mem_dpra, i);
            tick;
        end
        chk("run_cc3", cycle_count, 3);
        chk("run_still", cpu_run, 1);
        cpu_pc = 3; mem_dpo = 32'hFC00_0000;
        tick;
        chk("halt_cc", cycle_count, 4);
        chk("halt_halted", halted, 1);
        chk("halt_run", cpu_run, 0);
        chk("halt_err", err, 0);
        tick; tick;
        chk("halt_frozen", cycle_count, 4);
        mem_dpo = 0; cpu_pc = 0;
        // Load with two idle cycles before every word
        load(11'd5);
        chk("gap_cc_clr", cycle_count, 0);
        chk("gap_halt_clr", halted, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 0;
            for (int g = 0; g < 2; g++) begin
                settle;
                chk($sformatf("gap_idle_we%0d_%0d", i, g), mem_we, 0);
                chk($sformatf("gap_ready%0d_%0d", i, g), in_ready, 1);
                tick;
            end
            in_valid = 1; in_data = 32'hB000_0000 + i;
            settle;
            chk($sformatf("gap_we%0d", i), mem_we, 1);
            chk($sformatf("gap_a%0d", i), mem_a, i);
            tick;
        end
        in_valid = 0;
        settle;
        chk("gap_run", cpu_run, 1);
        // load_start while running must be ignored
        load(11'd3);
        chk("run_ign_run", cpu_run, 1);
        chk("run_ign_ready", in_ready, 0);
        chk("run_ign_cc", cycle_count, 1);
        // PC outside the memory window
        cpu_pc = 32'h0000_0400;
        settle;
        chk("badpc_dpra", mem_dpra, 0);
        tick;
        chk("badpc_err", err, 1);
        chk("badpc_halt", halted, 1);
        chk("badpc_run", cpu_run, 0);
        chk("badpc_cc", cycle_count, 2);
        cpu_pc = 0;
        // Reset after two of five words, with load_start and in_valid held high
        load(11'd5);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = i;
            tick;
        end
        rst_n = 0; load_start = 1; load_len = 5; in_valid = 1;
        tick;
        rst_n = 1; load_start = 0; in_valid = 0;
        settle;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_run", cpu_run, 0);
        chk("mid_rst_halt", halted, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cc", cycle_count, 0);
        tick;
        chk("mid_rst_idle", in_ready, 0);
        load(11'd5);
        in_valid = 1; in_data = 32'hC0DE_0000;
        settle;
        chk("mid_rst_cnt0", mem_a, 0);
        chk("mid_rst_we", mem_we, 1);
        tick;
        in_valid = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
